vga_scanout: RTL and testbench

- Read end of the 160x120 pixel frame buffer. Pixel writers such as the screen-update logic fill the buffer; this block reads it back.
- Generates 640x480@60 timing from a divide-by-2 pixel tick on the 50 MHz clock.
- Fetches each buffer pixel through a one-cycle-latency synchronous read port and replicates it 4x4.
- Drives the VGA DAC pins and gives the game control FSM a per-frame strobe.

---
 rtl/vga_pkg.sv | 64 ++++++
 rtl/vga_timing_counter.sv | 55 +++++
 rtl/vga_scanout.sv | 128 ++++++++++++
 tb/tb_vga_scanout.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing and frame-buffer constants for the scan-out path and the buffer writers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

  // 640x480@60 timing, in pixel ticks (horizontal) and lines (vertical)
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START_I = H_ACTIVE + H_FP;
  localparam int H_SYNC_END_I   = H_SYNC_START_I + H_SYNC - 1;
  localparam int V_SYNC_START_I = V_ACTIVE + V_FP;
  localparam int V_SYNC_END_I   = V_SYNC_START_I + V_SYNC - 1;

  // Frame buffer geometry: each buffer pixel covers a 4x4 block on screen
  localparam int SCALE_SHIFT = 2;
  localparam int FB_WIDTH    = 160;
  localparam int FB_HEIGHT   = V_ACTIVE >> SCALE_SHIFT;
  localparam int COLOUR_BITS = 3;
  localparam int ADDR_WIDTH  = 15;
  localparam int DAC_BITS    = 10;

  localparam int H_CNT_W = $clog2(H_TOTAL);
  localparam int V_CNT_W = $clog2(V_TOTAL);

  typedef logic [H_CNT_W-1:0]     h_cnt_t;
  typedef logic [V_CNT_W-1:0]     v_cnt_t;
  typedef logic [COLOUR_BITS-1:0] colour_t;
  typedef logic [ADDR_WIDTH-1:0]  fb_addr_t;

  // Counter-width copies of the timing boundaries
  localparam h_cnt_t H_LAST       = h_cnt_t'(H_TOTAL - 1);
  localparam v_cnt_t V_LAST       = v_cnt_t'(V_TOTAL - 1);
  localparam h_cnt_t H_ACT_END    = h_cnt_t'(H_ACTIVE);
  localparam v_cnt_t V_ACT_END    = v_cnt_t'(V_ACTIVE);
  localparam h_cnt_t H_SYNC_FIRST = h_cnt_t'(H_SYNC_START_I);
  localparam h_cnt_t H_SYNC_LAST  = h_cnt_t'(H_SYNC_END_I);
  localparam v_cnt_t V_SYNC_FIRST = v_cnt_t'(V_SYNC_START_I);
  localparam v_cnt_t V_SYNC_LAST  = v_cnt_t'(V_SYNC_END_I);

  // {R,G,B} encodings shared with the screen-update writer
  localparam colour_t COL_WHITE = 3'b111;
  localparam colour_t COL_RED   = 3'b100;
  localparam colour_t COL_BLACK = 3'b000;

  // Buffer address of the pixel under screen position (h, v).
  // FB_WIDTH = 160 = 128 + 32, so the row multiply is two shifts and an add.
  function automatic fb_addr_t fb_addr(input h_cnt_t h, input v_cnt_t v);
    fb_addr_t x;
    fb_addr_t y;
    x = fb_addr_t'(h >> SCALE_SHIFT);
    y = fb_addr_t'(v >> SCALE_SHIFT);
    return (y << 7) + (y << 5) + x;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-tick generator and h/v raster counters, plus a registered start-of-frame pulse.
// Latency: tick is combinational from phase; frame_start is registered on the tick that sees h=0,v=0.
// Backpressure: none; free-running once reset is released.
//
// Ports:
//   i_clk, i_rst_n  : 50 MHz clock, async active-low reset
//   o_phase         : divide-by-2 phase (0 after reset)
//   o_tick          : pixel tick, high while phase==1
//   o_h_cnt/o_v_cnt : raster position, advanced on tick
//   o_frame_start   : one-clk pulse for the tick at h=0,v=0
module vga_timing_counter
  import vga_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  output logic   o_phase,
  output logic   o_tick,
  output h_cnt_t o_h_cnt,
  output v_cnt_t o_v_cnt,
  output logic   o_frame_start
);

  logic   r_phase;
  h_cnt_t r_h_cnt;
  v_cnt_t r_v_cnt;
  logic   r_frame_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase       <= 1'b0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_phase       <= ~r_phase;
      r_frame_start <= r_phase && (r_h_cnt == '0) && (r_v_cnt == '0);
      if (r_phase) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          if (r_v_cnt == V_LAST) r_v_cnt <= '0;
          else                   r_v_cnt <= r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
      end
    end
  end

  assign o_phase       = r_phase;
  assign o_tick        = r_phase;
  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer read-out: 640x480@60 timing, 4x4 pixel replication, VGA DAC pin drive.
// Latency: raster position to pins is one pixel tick (2 clk); rd_data is taken 1 clk after rd_en.
// Backpressure: none; the buffer read port must answer every rd_en with data one clk later.
//
// Ports:
//   clk, resetn                 : 50 MHz clock, async active-low reset
//   rd_addr, rd_en, rd_data     : synchronous frame-buffer read port ({R,G,B})
//   frame_start                 : one-clk pulse at raster h=0,v=0
//   VGA_CLK, VGA_HS, VGA_VS     : 25 MHz pixel clock, active-low syncs
//   VGA_BLANK_N, VGA_SYNC_N     : blanking (low outside active), sync-on-green (tied 0)
//   VGA_R, VGA_G, VGA_B         : 10-bit DAC channels
module vga_scanout
  import vga_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_en,
  input  logic [COLOUR_BITS-1:0] rd_data,
  output logic                   frame_start,
  output logic                   VGA_CLK,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic [DAC_BITS-1:0]    VGA_R,
  output logic [DAC_BITS-1:0]    VGA_G,
  output logic [DAC_BITS-1:0]    VGA_B
);

  logic   w_phase;
  logic   w_tick;
  logic   w_frame_start;
  h_cnt_t w_h_cnt;
  v_cnt_t w_v_cnt;
  logic   w_active;
  logic   w_hs;
  logic   w_vs;

  // Stage 0: read request and delayed timing flags
  logic     r_rd_en;
  fb_addr_t r_rd_addr;
  logic     r_active_d;
  logic     r_hs_d;
  logic     r_vs_d;

  // Stage 1: pin registers
  logic                r_vga_clk;
  logic                r_hs_n;
  logic                r_vs_n;
  logic                r_blank_n;
  logic [DAC_BITS-1:0] r_r;
  logic [DAC_BITS-1:0] r_g;
  logic [DAC_BITS-1:0] r_b;

  vga_timing_counter u_tc (
    .i_clk         (clk),
    .i_rst_n       (resetn),
    .o_phase       (w_phase),
    .o_tick        (w_tick),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_frame_start (w_frame_start)
  );

  assign w_active = (w_h_cnt < H_ACT_END) && (w_v_cnt < V_ACT_END);
  assign w_hs     = (w_h_cnt >= H_SYNC_FIRST) && (w_h_cnt <= H_SYNC_LAST);
  assign w_vs     = (w_v_cnt >= V_SYNC_FIRST) && (w_v_cnt <= V_SYNC_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_active_d <= 1'b0;
      r_hs_d     <= 1'b0;
      r_vs_d     <= 1'b0;
    end else begin
      // rd_en is a single-clk strobe; rd_addr holds through blanking
      r_rd_en <= 1'b0;
      if (w_tick) begin
        r_rd_en    <= w_active;
        r_active_d <= w_active;
        r_hs_d     <= w_hs;
        r_vs_d     <= w_vs;
        if (w_active) r_rd_addr <= fb_addr(w_h_cnt, w_v_cnt);
      end
    end
  end

  // Stage 1 fires on the tick after stage 0; rd_data has been stable since
  // the clk in between, and stage-0 flags keep syncs aligned with colour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vga_clk <= 1'b0;
      r_hs_n    <= 1'b1;
      r_vs_n    <= 1'b1;
      r_blank_n <= 1'b0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
    end else begin
      // Follows the phase flop, so VGA_CLK rises one clk after the pins
      // change and the DAC samples mid-pixel.
      r_vga_clk <= ~w_phase;
      if (w_tick) begin
        r_hs_n    <= ~r_hs_d;
        r_vs_n    <= ~r_vs_d;
        r_blank_n <= r_active_d;
        r_r       <= r_active_d ? {DAC_BITS{rd_data[2]}} : '0;
        r_g       <= r_active_d ? {DAC_BITS{rd_data[1]}} : '0;
        r_b       <= r_active_d ? {DAC_BITS{rd_data[0]}} : '0;
      end
    end
  end

  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;
  assign frame_start = w_frame_start;
  assign VGA_CLK     = r_vga_clk;
  assign VGA_HS      = r_hs_n;
  assign VGA_VS      = r_vs_n;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: reset values, first-tick timing, 4x4 colour
// replication, line timing, end-of-frame addressing, vsync lines, frame wrap,
// and asynchronous reset mid-frame.
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [14:0] rd_addr;
  logic        rd_en;
  logic [2:0]  rd_data;
  logic        frame_start;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0]  VGA_R, VGA_G, VGA_B;

  logic [2:0]  fb [0:19199];
  logic [9:0]  jh, jv;

  int n_tests = 0;
  int n_fail  = 0;

  vga_scanout dut (
    .clk         (clk),
    .resetn      (resetn),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .frame_start (frame_start),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  always #10 clk = ~clk;

  // Synchronous-read buffer model, one clk latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= fb[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rd_en"},   32'(rd_en),       0);
    chk({tag, "_rd_addr"}, 32'(rd_addr),     0);
    chk({tag, "_fs"},      32'(frame_start), 0);
    chk({tag, "_vclk"},    32'(VGA_CLK),     0);
    chk({tag, "_hs"},      32'(VGA_HS),      1);
    chk({tag, "_vs"},      32'(VGA_VS),      1);
    chk({tag, "_blank"},   32'(VGA_BLANK_N), 0);
    chk({tag, "_sync"},    32'(VGA_SYNC_N),  0);
    chk({tag, "_r"},       32'(VGA_R),       0);
    chk({tag, "_g"},       32'(VGA_G),       0);
    chk({tag, "_b"},       32'(VGA_B),       0);
  endtask

  // Move the raster to (h, v): the first tick edge after return processes (h, v).
  task automatic jump(input int h, input int v);
    @(negedge clk);
    for (int i = 0; i < 4 && dut.u_tc.r_phase !== 1'b0; i++) @(negedge clk);
    jh = 10'(h);
    jv = 10'(v);
    force dut.u_tc.r_h_cnt = jh;
    force dut.u_tc.r_v_cnt = jv;
    @(negedge clk);
    release dut.u_tc.r_h_cnt;
    release dut.u_tc.r_v_cnt;
  endtask

  initial begin
    int cnt_blank, cnt_hs, first_hs, cnt_rd, cnt_fs, cnt_vs, first_vs, errs, k;
    for (int i = 0; i < 19200; i++) fb[i] = 3'b000;
    fb[0]    = 3'b111;
    fb[1]    = 3'b100;
    fb[8075] = 3'b111;
    rd_data  = 3'b000;

    // Reset held for 5 clk
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    check_reset("rst");

    // Release and walk line 0: sample n observes state after the n-th posedge
    resetn    = 1'b1;
    cnt_blank = 0; cnt_hs = 0; first_hs = -1; cnt_rd = 0; cnt_fs = 0;
    for (int n = 1; n <= 1603; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("t1_fs", 32'(frame_start), 0);
        chk("t1_rd_en", 32'(rd_en), 0);
      end
      if (n == 2) begin
        chk("t2_fs", 32'(frame_start), 1);
        chk("t2_rd_en", 32'(rd_en), 1);
        chk("t2_rd_addr", 32'(rd_addr), 0);
      end
      if (n == 4) chk("vclk_at_pin_update", 32'(VGA_CLK), 0);
      if (n == 5) chk("vclk_mid_pixel", 32'(VGA_CLK), 1);
      if (n == 8) chk("addr_px3", 32'(rd_addr), 0);
      if (n == 10) chk("addr_px4", 32'(rd_addr), 1);
      if (n >= 4 && n <= 19 && (n % 2) == 0) begin
        k = (n - 4) / 2;
        chk($sformatf("px%0d_r", k), 32'(VGA_R), 32'h3FF);
        chk($sformatf("px%0d_g", k), 32'(VGA_G), (k < 4) ? 32'h3FF : 32'h0);
        chk($sformatf("px%0d_b", k), 32'(VGA_B), (k < 4) ? 32'h3FF : 32'h0);
      end
      if (n >= 4) begin
        if (VGA_BLANK_N === 1'b1) cnt_blank++;
        if (VGA_HS === 1'b0) begin
          cnt_hs++;
          if (first_hs < 0) first_hs = n;
        end
      end
      if (n <= 1601 && rd_en === 1'b1) cnt_rd++;
      if (frame_start === 1'b1) cnt_fs++;
    end
    chk("line0_blank_clk", cnt_blank, 1280);
    chk("line0_hs_low_clk", cnt_hs, 192);
    chk("line0_hs_first", first_hs, 1316);
    chk("line0_rd_en_cnt", cnt_rd, 640);
    chk("line0_fs_cnt", cnt_fs, 1);

    // Lines 476..479 all map to buffer row 119: addresses 19040..19199
    jump(0, 476);
    cnt_rd = 0; errs = 0;
    for (int m = 1; m <= 6400; m++) begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        if (int'(rd_addr) != 19040 + (cnt_rd % 640) / 4) errs++;
        cnt_rd++;
      end
      if (m == 6079) chk("addr_h639_v479", 32'(rd_addr), 19199);
    end
    chk("l476_479_rd_cnt", cnt_rd, 2560);
    chk("l476_479_addr_errs", errs, 0);

    // Lines 489..492: vsync low on 490-491 only, no reads, blank throughout
    jump(0, 489);
    cnt_vs = 0; first_vs = -1; cnt_rd = 0; cnt_blank = 0;
    for (int m = 1; m <= 6404; m++) begin
      @(negedge clk);
      if (m >= 3) begin
        if (VGA_VS === 1'b0) begin
          cnt_vs++;
          if (first_vs < 0) first_vs = m;
        end
        if (VGA_BLANK_N === 1'b1) cnt_blank++;
      end
      if (rd_en === 1'b1) cnt_rd++;
    end
    chk("vs_low_clk", cnt_vs, 3200);
    chk("vs_first", first_vs, 1603);
    chk("vblank_rd_en_cnt", cnt_rd, 0);
    chk("vblank_blank_clk", cnt_blank, 0);

    // Frame wrap: h=795,v=524 -> five ticks later h=0,v=0
    jump(795, 524);
    cnt_fs = 0;
    for (int m = 1; m <= 14; m++) begin
      @(negedge clk);
      if (frame_start === 1'b1) cnt_fs++;
      if (m == 9) chk("wrap_h799_fs", 32'(frame_start), 0);
      if (m == 11) begin
        chk("wrap_fs", 32'(frame_start), 1);
        chk("wrap_rd_en", 32'(rd_en), 1);
        chk("wrap_rd_addr", 32'(rd_addr), 0);
      end
    end
    chk("wrap_fs_cnt", cnt_fs, 1);

    // Asynchronous reset at h=300,v=200, between clock edges
    jump(300, 200);
    repeat (4) @(negedge clk);
    chk("pre_rst_addr", 32'(rd_addr), 8075);
    chk("pre_rst_blank", 32'(VGA_BLANK_N), 1);
    chk("pre_rst_r", 32'(VGA_R), 32'h3FF);
    #5;
    resetn = 1'b0;
    #1;
    check_reset("arst");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) chk("rel_t1_fs", 32'(frame_start), 0);
      if (n == 2) begin
        chk("rel_t2_fs", 32'(frame_start), 1);
        chk("rel_t2_rd_en", 32'(rd_en), 1);
        chk("rel_t2_rd_addr", 32'(rd_addr), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
